// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared seven-segment constants for the display blocks.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package bcd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Entry i holds the pattern for decimal digit i (entry 0 is the LS slice).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg -- combinational digit-to-segment decoder.
//   digit : N-bit BCD value (values above 9 show a dash)
//   blank : force all segments off
//   seg   : active-low {g,f,e,d,c,b,a}
module bcd_to_seg
    import bcd_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] digit,
    input  logic         blank,
    output logic [6:0]   seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank)
            seg = SEG_BLANK;
        else if (digit <= N'(9))
            seg = SEG_TABLE[digit[3:0]];
    end

endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan -- multiplexed BCD seven-segment scanner.
//   clk, rst       : clock, asynchronous active-low reset
//   digits_in      : DIGITS packed BCD nibbles, digit 0 in the LS nibble
//   load           : capture digits_in into the display snapshot
//   blank_lz       : suppress leading zeros (digit 0 always shown)
//   an             : active-low one-cold digit enables (registered)
//   seg            : active-low segments {g,f,e,d,c,b,a} (registered)
//   frame_done     : one-cycle pulse after the scan wraps to digit 0
module bcd_display_scan
    import bcd_pkg::*;
#(
    parameter int N           = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*DIGITS-1:0]   digits_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);

    logic [DIGITS-1:0][N-1:0] snap;
    logic [CW-1:0]            cnt;
    logic [IW-1:0]            idx;
    logic                     tc;
    logic                     wrap;
    logic                     upper_nz;
    logic                     blank;
    logic [DIGITS-1:0]        an_next;
    logic [6:0]               seg_next;

    assign tc   = (cnt == CW'(REFRESH_DIV - 1));
    assign wrap = tc && (idx == IW'(DIGITS - 1));

    // A digit is a leading zero when it and every digit above it are zero.
    // Invalid (>9) digits are non-zero, so they stop the blanking run.
    always_comb begin
        upper_nz = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            if (k >= int'(idx) && snap[k] != '0)
                upper_nz = 1'b1;
        blank = blank_lz && (idx != '0) && !upper_nz;
    end

    always_comb begin
        an_next      = '1;
        an_next[idx] = 1'b0;
    end

    bcd_to_seg #(.N(N)) u_dec (
        .digit (snap[idx]),
        .blank (blank),
        .seg   (seg_next)
    );

    // Outputs are registered from the pre-edge index/snapshot, so a load
    // coinciding with the terminal count is first seen together with the new
    // index one cycle later -- never the new index with the old snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap       <= '0;
            cnt        <= '0;
            idx        <= '0;
            an         <= '1;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            if (load)
                snap <= digits_in;
            cnt <= tc ? '0 : cnt + CW'(1);
            if (tc)
                idx <= wrap ? '0 : idx + IW'(1);
            frame_done <= wrap;
            an         <= an_next;
            seg        <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
module tb_bcd_display_scan;

    localparam int N = 4;
    localparam int D = 4;
    localparam int R = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   digits_in = '0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset release and the captured value.
    int          m_t = 0;
    logic [15:0] m_snap = '0;

    bcd_display_scan #(.N(N), .DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_pattern(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // What the display should show for position p of value v.
    function automatic logic [6:0] expect_seg(input logic [15:0] v, input int p, input logic blz);
        int upper;
        int d;
        upper = int'(v) >> (4 * p);
        d     = upper % 16;
        if (p > 0 && blz && upper == 0) return 7'b1111111;
        return digit_pattern(d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, m_t);
        end
    endtask

    // One clock: drive inputs, take the edge, compare against the model.
    task automatic step(input logic ld, input logic [15:0] din, input logic blz);
        int          pos;
        logic [15:0] pv;
        logic [3:0]  ea;
        load      = ld;
        digits_in = din;
        blank_lz  = blz;
        pos = (m_t / R) % D;
        pv  = m_snap;
        @(posedge clk);
        m_t++;
        if (ld) m_snap = din;
        #1;
        ea = 4'hF;
        ea[pos] = 1'b0;
        chk("an", 32'(an), 32'(ea));
        chk("seg", 32'(seg), 32'(expect_seg(pv, pos, blz)));
        chk("frame_done", 32'(frame_done), 32'((m_t % (R * D)) == 0));
        load = 1'b0;
    endtask

    task automatic run(input int n, input logic blz);
        for (int i = 0; i < n; i++) step(1'b0, digits_in, blz);
    endtask

    initial begin
        // Reset state while held, across clock edges.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_fd", 32'(frame_done), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        m_t = 0;
        m_snap = '0;

        // All zeros with blanking: single "0" then blanks.
        step(1'b1, 16'h0000, 1'b1);
        run(20, 1'b1);

        // 1234 without blanking, two full frames.
        step(1'b1, 16'h1234, 1'b0);
        run(34, 1'b0);

        // 0050 with blanking.
        step(1'b1, 16'h0050, 1'b1);
        run(18, 1'b1);

        // Invalid digit stops blanking and shows a dash.
        step(1'b1, 16'h0A07, 1'b1);
        run(18, 1'b1);

        // Load on terminal-count edges.
        for (int j = 0; j < 6; j++) begin
            while (((m_t + 1) % R) != 0) step(1'b0, digits_in, 1'b1);
            step(1'b1, 16'(j * 16'h1111 + 16'h0102), 1'b1);
            run(2, 1'b1);
        end

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if ($urandom_range(0, 1) == 0) v[15:8] = 8'h00;
            if ($urandom_range(0, 2) == 0) v[15:12] = 4'h0;
            step(($urandom_range(0, 5) == 0), v, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges.
        run(5, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_fd", 32'(frame_done), 32'h0);
        @(posedge clk);
        #1;
        chk("held_an", 32'(an), 32'hF);
        @(negedge clk);
        rst = 1'b1;
        m_t = 0;
        m_snap = '0;
        step(1'b0, 16'h9876, 1'b1);
        step(1'b1, 16'h9876, 1'b0);
        run(40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 Parameter N, default 4: bits per BCD digit.
REQ-002 Parameter DIGITS, default 4: number of multiplexed digits, 2..8.
REQ-003 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot, >=2.
REQ-004 Port clk, input, 1: sole clock, all state on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-low.
REQ-006 Port digits_in, input, N*DIGITS: registered BCD counter digits; digit 0 is the LS nibble [N-1:0].
REQ-007 Port load, input, 1: capture digits_in into the snapshot this cycle.
REQ-008 Port blank_lz, input, 1: enable leading-zero blanking.
REQ-009 Port an, output, DIGITS: digit enables, active-low, one-cold.
REQ-010 Port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port frame_done, output, 1: one-cycle pulse at completion of a full scan.

Function
REQ-012 The block SHALL hold a snapshot register, width N*DIGITS, written with digits_in on any clk edge where load=1; otherwise it is held.
REQ-013 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the terminal count is value REFRESH_DIV-1.
REQ-014 On terminal count the digit index SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-015 frame_done SHALL be 1 for exactly the cycle after the index wraps from DIGITS-1 to 0, otherwise 0.
REQ-016 an and seg SHALL be registered: one clk of latency after an index or snapshot change.
REQ-017 an SHALL drive 0 only on the bit equal to the current index; all other bits are 1.
REQ-018 Decode: values 0-9 map to standard patterns (0=7'b1000000, 1=7'b1111001, 8=7'b0000000); values 10-15 map to dash 7'b0111111.
REQ-019 Digit k>0 SHALL be blanked (seg=7'b1111111, an still asserted) when blank_lz=1 and snapshot digits k..DIGITS-1 are all zero.
REQ-020 Digit 0 SHALL never be blanked; an all-zero snapshot shows a single "0".
REQ-021 An invalid digit (>9) SHALL count as non-zero for blanking and display as dash.
REQ-022 When load and terminal count coincide, both take effect; the new index is decoded from the new snapshot in the next cycle.
REQ-023 blank_lz changes SHALL take effect on the next registered output update, no synchronisation required.

Reset
REQ-024 While rst=0: snapshot=0, refresh counter=0, index=0, an=all 1s, seg=7'b1111111, frame_done=0.
REQ-025 First clk edge after rst release SHALL drive an=~1 (digit 0) and seg=pattern for "0".
REQ-026 Reset asserted mid-scan SHALL clear all state immediately, regardless of clk.

Structure
REQ-027 Segment constants (digit patterns, DASH, BLANK) SHALL live in the shared bcd_pkg include, reused by other display blocks.
REQ-028 Digit-to-segment decode SHALL be a combinational sub-module bcd_to_seg (in: N-bit digit, blank; out: 7-bit seg).
REQ-029 Refresh counter width SHALL be $clog2(REFRESH_DIV); index width $clog2(DIGITS).

Verification (REFRESH_DIV=4, DIGITS=4)
REQ-030 Reset release, digits_in=16'h0000, load pulse -> an cycles 1110,1101,1011,0111 every 4 clk, seg=1000000 then blank x3 with blank_lz=1.
REQ-031 load with 16'h1234, blank_lz=0 -> digit0 seg shows 4, digit3 shows 1; frame_done pulses once per 16 clk.
REQ-032 load 16'h0050, blank_lz=1 -> digits 3,2 blank, digit1 "5", digit0 "0".
REQ-033 load 16'h0A07 -> digit2 shows dash, digit3 blanked (blank_lz=1), digit1 "0" not blanked.
REQ-034 load asserted on terminal-count cycle with new value -> next displayed digit uses new snapshot, no glitch cycle with old value.
REQ-035 rst asserted mid-slot between clk edges -> an=1111, seg=1111111, frame_done=0 immediately; scan restarts at digit 0.
